// File: rtl/mem_arbiter_pkg.sv
// Shared memory-port types for the arbiter: command encoding, data word and a read-command helper.
package mem_arbiter_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [2:0] {
        MEM_CTRL_NONE       = 3'd0,
        MEM_CTRL_READ_BYTE  = 3'd1,
        MEM_CTRL_READ_HALF  = 3'd2,
        MEM_CTRL_READ_WORD  = 3'd3,
        MEM_CTRL_STORE_BYTE = 3'd4,
        MEM_CTRL_STORE_HALF = 3'd5,
        MEM_CTRL_STORE_WORD = 3'd6
    } mem_ctrl_t;

    function automatic logic mem_ctrl_is_read(input mem_ctrl_t c);
        case (c)
            MEM_CTRL_READ_BYTE,
            MEM_CTRL_READ_HALF,
            MEM_CTRL_READ_WORD: return 1'b1;
            default:            return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational picker: first requester found searching upward from i_base, wrapping modulo NPORTS.
module mem_arb_pick #(
    parameter int NPORTS = 2,
    parameter int IDX_W  = $clog2(NPORTS)
) (
    input  logic [NPORTS-1:0] i_req,
    input  logic [IDX_W-1:0]  i_base,
    output logic [NPORTS-1:0] o_grant,
    output logic [IDX_W-1:0]  o_idx,
    output logic              o_any
);

    // Priority search; once a winner is found later candidates are masked by o_any
    always_comb begin : p_pick
        int   j;
        logic hit;
        j       = 0;
        hit     = 1'b0;
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        for (int k = 0; k < NPORTS; k++) begin
            j          = (int'(i_base) + k >= NPORTS) ? int'(i_base) + k - NPORTS : int'(i_base) + k;
            hit        = ~o_any & i_req[j];
            o_idx      = hit ? IDX_W'(j) : o_idx;
            o_grant[j] = o_grant[j] | hit;
            o_any      = o_any | hit;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port among NPORTS requesters with a one-deep read-return pipeline.
// Define MEM_ARB_RR_EN for round-robin arbitration; default build is fixed priority (lowest index wins).
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int NPORTS = 2,
    parameter int IDX_W  = $clog2(NPORTS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NPORTS-1:0] req_valid,
    input  mem_ctrl_t         req_ctrl  [NPORTS],
    input  word_t             req_addr  [NPORTS],
    input  word_t             req_wdata [NPORTS],
    output logic [NPORTS-1:0] req_ready,
    output logic [NPORTS-1:0] rsp_valid,
    output word_t             rsp_rdata,
    output mem_ctrl_t         mem_ctrl,
    output word_t             mem_addr,
    output word_t             mem_din,
    input  word_t             mem_dout
);

    logic [NPORTS-1:0] w_req;
    logic [NPORTS-1:0] w_grant;
    logic [IDX_W-1:0]  w_idx;
    logic              w_any;
    logic [IDX_W-1:0]  w_base;
    logic              w_rd_issue;
    logic              r_rd_pend;
    logic [IDX_W-1:0]  r_rd_owner;

    // Eligible requesters; reset suppresses every grant
    always_comb begin
        w_req = '0;
        for (int i = 0; i < NPORTS; i++) begin
            w_req[i] = req_valid[i] & (req_ctrl[i] != MEM_CTRL_NONE) & ~rst;
        end
    end

    mem_arb_pick #(
        .NPORTS (NPORTS),
        .IDX_W  (IDX_W)
    ) u_pick (
        .i_req   (w_req),
        .i_base  (w_base),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

`ifdef MEM_ARB_RR_EN
    logic [IDX_W-1:0] r_rr_ptr;

    // Next search starts just past the last winner; idle cycles keep the pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else if (w_any) begin
            r_rr_ptr <= (int'(w_idx) == NPORTS - 1) ? '0 : w_idx + IDX_W'(1);
        end else begin
            r_rr_ptr <= r_rr_ptr;
        end
    end

    assign w_base = r_rr_ptr;
`else
    assign w_base = '0;
`endif

    // Winner's command steers the memory port in the grant cycle
    always_comb begin
        req_ready = w_grant;
        mem_ctrl  = MEM_CTRL_NONE;
        mem_addr  = 32'h0000_0000;
        mem_din   = 32'h0000_0000;
        if (w_any) begin
            mem_ctrl = req_ctrl[w_idx];
            mem_addr = req_addr[w_idx];
            mem_din  = req_wdata[w_idx];
        end else begin
            mem_ctrl = MEM_CTRL_NONE;
        end
    end

    assign w_rd_issue = mem_ctrl_is_read(mem_ctrl);

    // Remember who issued this cycle's read so the data returns to them next cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_pend  <= 1'b0;
            r_rd_owner <= '0;
        end else begin
            r_rd_pend  <= w_rd_issue;
            r_rd_owner <= w_rd_issue ? w_idx : r_rd_owner;
        end
    end

    // Response strobe; a read caught by reset never reports back
    always_comb begin
        rsp_valid             = '0;
        rsp_valid[r_rd_owner] = r_rd_pend & ~rst;
    end

    assign rsp_rdata = mem_dout;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic against a reference model.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int NP = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [NP-1:0] req_valid;
    mem_ctrl_t     req_ctrl  [NP];
    word_t         req_addr  [NP];
    word_t         req_wdata [NP];
    logic [NP-1:0] req_ready;
    logic [NP-1:0] rsp_valid;
    word_t         rsp_rdata;
    mem_ctrl_t     mem_ctrl;
    word_t         mem_addr;
    word_t         mem_din;
    word_t         mem_dout;

    mem_arbiter #(.NPORTS(NP)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ctrl  (req_ctrl),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .mem_ctrl  (mem_ctrl),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout)
    );

    always #5 clk = ~clk;

    typedef logic [7:0] mem_arr_t [256];
    mem_arr_t dev_mem;
    mem_arr_t ref_mem;

    typedef struct {
        int    port;
        word_t data;
        int    due;
    } rsp_t;
    rsp_t q[$];

    int        checks = 0;
    int        errors = 0;
    int        cyc    = 0;
    int        ptr    = 0;
    logic [NP-1:0] obs_ready;
    logic [NP-1:0] obs_rsp;
    word_t         obs_rdata;
    mem_ctrl_t     obs_ctrl;

    function automatic int nbytes(input mem_ctrl_t c);
        case (c)
            MEM_CTRL_READ_BYTE, MEM_CTRL_STORE_BYTE: return 1;
            MEM_CTRL_READ_HALF, MEM_CTRL_STORE_HALF: return 2;
            MEM_CTRL_READ_WORD, MEM_CTRL_STORE_WORD: return 4;
            default: return 0;
        endcase
    endfunction

    function automatic word_t rd_bytes(input mem_arr_t m, input word_t a, input int n);
        word_t d;
        d = 32'h0;
        for (int k = 0; k < n; k++) d[8*k +: 8] = m[8'(int'(a[7:0]) + k)];
        return d;
    endfunction

    // Behavioural memory: stores land at the edge, reads return at the edge
    always @(posedge clk) begin
        for (int k = 0; k < 4; k++)
            if (k < nbytes(mem_ctrl) && !mem_ctrl_is_read(mem_ctrl))
                dev_mem[8'(int'(mem_addr[7:0]) + k)] <= mem_din[8*k +: 8];
        if (mem_ctrl_is_read(mem_ctrl))
            mem_dout <= rd_bytes(dev_mem, mem_addr, nbytes(mem_ctrl));
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%h exp=%h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int ref_winner();
        for (int k = 0; k < NP; k++) begin
            int p;
            p = (ptr + k) % NP;
            if (!rst && req_valid[p] && req_ctrl[p] != MEM_CTRL_NONE) return p;
        end
        return -1;
    endfunction

    // One clock: compare DUT against the model at negedge, advance the model at posedge
    task automatic cycle();
        int            w;
        logic [NP-1:0] exp_rsp;
        word_t         exp_data;
        rsp_t          r;
        @(negedge clk);
        w         = ref_winner();
        obs_ready = req_ready;
        obs_rsp   = rsp_valid;
        obs_rdata = rsp_rdata;
        obs_ctrl  = mem_ctrl;
        check_val("req_ready", 32'(req_ready), (w >= 0) ? (32'd1 << w) : 32'd0);
        check_val("mem_ctrl", 32'(mem_ctrl), (w >= 0) ? 32'(req_ctrl[w]) : 32'(MEM_CTRL_NONE));
        check_val("mem_addr", mem_addr, (w >= 0) ? req_addr[w] : 32'd0);
        check_val("mem_din", mem_din, (w >= 0) ? req_wdata[w] : 32'd0);
        exp_rsp  = '0;
        exp_data = 32'h0;
        if (rst) begin
            q.delete();
        end else if (q.size() > 0 && q[0].due == cyc) begin
            r = q.pop_front();
            exp_rsp[r.port] = 1'b1;
            exp_data = r.data;
        end
        check_val("rsp_valid", 32'(rsp_valid), 32'(exp_rsp));
        if (exp_rsp != '0) check_val("rsp_rdata", rsp_rdata, exp_data);
        @(posedge clk);
        if (w >= 0) begin
            if (mem_ctrl_is_read(req_ctrl[w])) begin
                q.push_back('{w, rd_bytes(ref_mem, req_addr[w], nbytes(req_ctrl[w])), cyc + 1});
            end else begin
                for (int k = 0; k < nbytes(req_ctrl[w]); k++)
                    ref_mem[8'(int'(req_addr[w][7:0]) + k)] = req_wdata[w][8*k +: 8];
            end
`ifdef MEM_ARB_RR_EN
            ptr = (w + 1) % NP;
`endif
        end
        if (rst) ptr = 0;
        cyc++;
        #1;
    endtask

    task automatic set_req(input int p, input logic v, input mem_ctrl_t c, input word_t a, input word_t d);
        req_valid[p] = v;
        req_ctrl[p]  = c;
        req_addr[p]  = a;
        req_wdata[p] = d;
    endtask

    task automatic idle_all();
        for (int p = 0; p < NP; p++) set_req(p, 1'b0, MEM_CTRL_NONE, 32'h0, 32'h0);
    endtask

    initial begin
        logic [NP-1:0] exp_g;
        for (int i = 0; i < 256; i++) begin
            dev_mem[i] <= 8'h00;
            ref_mem[i] = 8'h00;
        end
        dev_mem[8'h10] <= 8'h11; dev_mem[8'h11] <= 8'h22;
        dev_mem[8'h12] <= 8'h33; dev_mem[8'h13] <= 8'h44;
        ref_mem[8'h10] = 8'h11; ref_mem[8'h11] = 8'h22;
        ref_mem[8'h12] = 8'h33; ref_mem[8'h13] = 8'h44;
        mem_dout <= 32'h0;
        rst = 1'b1;
        idle_all();
        set_req(0, 1'b1, MEM_CTRL_READ_WORD, 32'h10, 32'h0);
        cycle();
        cycle();
        check_val("rst_ready", 32'(obs_ready), 32'd0);
        check_val("rst_ctrl", 32'(obs_ctrl), 32'(MEM_CTRL_NONE));
        rst = 1'b0;
        idle_all();
        cycle();

        // 1: lone read from port 1
        set_req(1, 1'b1, MEM_CTRL_READ_WORD, 32'h10, 32'h0);
        cycle();
        check_val("t1_ready", 32'(obs_ready), 32'h2);
        idle_all();
        cycle();
        check_val("t1_rsp", 32'(obs_rsp), 32'h2);
        check_val("t1_data", obs_rdata, 32'h4433_2211);

        // 2: simultaneous reads
        set_req(0, 1'b1, MEM_CTRL_READ_WORD, 32'h10, 32'h0);
        set_req(1, 1'b1, MEM_CTRL_READ_WORD, 32'h10, 32'h0);
        cycle();
        check_val("t2_ready_n", 32'(obs_ready), 32'h1);
        set_req(0, 1'b0, MEM_CTRL_NONE, 32'h0, 32'h0);
        cycle();
        check_val("t2_ready_n1", 32'(obs_ready), 32'h2);
        check_val("t2_rsp_n1", 32'(obs_rsp), 32'h1);
        check_val("t2_data_n1", obs_rdata, 32'h4433_2211);
        idle_all();
        cycle();
        check_val("t2_rsp_n2", 32'(obs_rsp), 32'h2);
        check_val("t2_data_n2", obs_rdata, 32'h4433_2211);

        // 3: store then read back
        set_req(0, 1'b1, MEM_CTRL_STORE_HALF, 32'h20, 32'h0000_BEEF);
        cycle();
        check_val("t3_ready", 32'(obs_ready), 32'h1);
        set_req(0, 1'b1, MEM_CTRL_READ_HALF, 32'h20, 32'h0);
        cycle();
        check_val("t3_rsp_n1", 32'(obs_rsp), 32'h0);
        idle_all();
        cycle();
        check_val("t3_rsp_n2", 32'(obs_rsp), 32'h1);
        check_val("t3_data", obs_rdata, 32'h0000_BEEF);

        // 4: reset discards an in-flight read
        set_req(0, 1'b1, MEM_CTRL_READ_WORD, 32'h10, 32'h0);
        cycle();
        rst = 1'b1;
        cycle();
        check_val("t4_ctrl", 32'(obs_ctrl), 32'(MEM_CTRL_NONE));
        check_val("t4_rsp", 32'(obs_rsp), 32'h0);
        cycle();
        rst = 1'b0;
        idle_all();
        for (int i = 0; i < 3; i++) begin
            cycle();
            check_val("t4_rsp_after", 32'(obs_rsp), 32'h0);
        end

        // 5: continuous contention
        set_req(0, 1'b1, MEM_CTRL_READ_WORD, 32'h10, 32'h0);
        set_req(1, 1'b1, MEM_CTRL_READ_WORD, 32'h10, 32'h0);
        for (int i = 0; i < 6; i++) begin
            cycle();
`ifdef MEM_ARB_RR_EN
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
`else
            exp_g = 2'b01;
`endif
            check_val("t5_grant", 32'(obs_ready), 32'(exp_g));
        end
        idle_all();
        cycle();

        // 6: valid with NONE command is never granted
        set_req(0, 1'b1, MEM_CTRL_NONE, 32'h30, 32'h0);
        set_req(1, 1'b1, MEM_CTRL_READ_WORD, 32'h10, 32'h0);
        cycle();
        check_val("t6_ready", 32'(obs_ready), 32'h2);
        check_val("t6_ctrl", 32'(obs_ctrl), 32'(MEM_CTRL_READ_WORD));
        set_req(1, 1'b0, MEM_CTRL_NONE, 32'h0, 32'h0);
        cycle();
        check_val("t6_ready_none", 32'(obs_ready), 32'h0);
        check_val("t6_ctrl_none", 32'(obs_ctrl), 32'(MEM_CTRL_NONE));
        idle_all();
        cycle();

        // Random traffic: requests hold until granted, occasional drops and resets
        for (int n = 0; n < 600; n++) begin
            for (int p = 0; p < NP; p++) begin
                if (!req_valid[p] || obs_ready[p]) begin
                    if ($urandom_range(0, 9) < 6)
                        set_req(p, 1'b1, mem_ctrl_t'($urandom_range(0, 6)),
                                32'($urandom_range(0, 255)), $urandom);
                    else
                        set_req(p, 1'b0, MEM_CTRL_NONE, 32'h0, 32'h0);
                end else if ($urandom_range(0, 15) == 0) begin
                    set_req(p, 1'b0, MEM_CTRL_NONE, 32'h0, 32'h0);
                end
            end
            rst = ($urandom_range(0, 99) == 0);
            cycle();
        end
        rst = 1'b0;
        idle_all();
        cycle();
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
